// File: rtl/pipelined_control_unit_if.sv
// Fetch-side handshake, downstream stall and registered control word of the
// pipelined control unit.
interface pipelined_control_unit_if #(
  parameter int unsigned INSN_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned REG_WIDTH  = 2,
  parameter int unsigned FUNC_WIDTH = 3
);
  logic                  insn_valid;
  logic [INSN_WIDTH-1:0] insn;
  logic                  insn_ready;
  logic                  stall;
  logic                  ctl_valid;
  logic                  halt;
  logic                  branch;
  logic                  jump;
  logic                  relative;
  logic [DATA_WIDTH-1:0] dest_branch_jump;
  logic [REG_WIDTH-1:0]  reg_a;
  logic [REG_WIDTH-1:0]  reg_b;
  logic                  reg_write;
  logic                  mux_ri;
  logic                  overflow_write;
  logic                  compare_write;
  logic                  memory_read;
  logic                  memory_write;
  logic                  mux_ma;
  logic [DATA_WIDTH-1:0] immediate_value;
  logic [FUNC_WIDTH-1:0] func_code;

  modport slave (
    input  insn_valid, insn, stall,
    output insn_ready, ctl_valid, halt, branch, jump, relative, dest_branch_jump,
           reg_a, reg_b, reg_write, mux_ri, overflow_write, compare_write,
           memory_read, memory_write, mux_ma, immediate_value, func_code
  );

  modport master (
    output insn_valid, insn, stall,
    input  insn_ready, ctl_valid, halt, branch, jump, relative, dest_branch_jump,
           reg_a, reg_b, reg_write, mux_ri, overflow_write, compare_write,
           memory_read, memory_write, mux_ma, immediate_value, func_code
  );
endinterface

// File: rtl/pipelined_control_unit.sv
// Registered instruction decoder: one insn per cycle into a control word, with
// load-use bubble, post-branch flush window and sticky halt.
module pipelined_control_unit #(
  parameter int unsigned FLAG_WIDTH     = 2,
  parameter int unsigned REG_WIDTH      = 2,
  parameter int unsigned FUNC_WIDTH     = 3,
  parameter int unsigned INSN_WIDTH     = FLAG_WIDTH + 2 * REG_WIDTH + FUNC_WIDTH,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned BRANCH_PENALTY = 2,
  parameter logic [FUNC_WIDTH-1:0] FUNC_ADD = 0,
  parameter logic [FUNC_WIDTH-1:0] FUNC_SUB = 1,
  parameter logic [FUNC_WIDTH-1:0] FUNC_LD  = 2,
  parameter logic [FUNC_WIDTH-1:0] FUNC_SV  = 3,
  parameter logic [FUNC_WIDTH-1:0] FUNC_LSS = 4,
  parameter logic [FUNC_WIDTH-1:0] FUNC_EQL = 5,
  parameter logic [FUNC_WIDTH-1:0] FUNC_GRT = 6,
  parameter logic [FUNC_WIDTH-1:0] FUNC_SET = 7
) (
  input  logic                      clk,
  input  logic                      rst_n,
  pipelined_control_unit_if.slave   bus_io
);

  localparam int unsigned ImmW = INSN_WIDTH - FLAG_WIDTH - REG_WIDTH;
  localparam int unsigned TgtW = INSN_WIDTH - FLAG_WIDTH - 2;
  localparam int unsigned CntW = (BRANCH_PENALTY > 1) ? $clog2(BRANCH_PENALTY) : 1;

  localparam logic [FLAG_WIDTH-1:0] FlagSet = FLAG_WIDTH'(0);
  localparam logic [FLAG_WIDTH-1:0] FlagBr  = FLAG_WIDTH'(1);
  localparam logic [FLAG_WIDTH-1:0] FlagOp  = FLAG_WIDTH'(2);
  localparam logic [FLAG_WIDTH-1:0] FlagSys = FLAG_WIDTH'(3);

  typedef enum logic [1:0] {StRun, StStall, StFlush, StHalted} state_e;

  typedef struct packed {
    logic                  valid;
    logic                  halt;
    logic                  branch;
    logic                  jump;
    logic                  relative;
    logic [DATA_WIDTH-1:0] dest;
    logic [REG_WIDTH-1:0]  reg_a;
    logic [REG_WIDTH-1:0]  reg_b;
    logic                  reg_write;
    logic                  mux_ri;
    logic                  overflow_write;
    logic                  compare_write;
    logic                  memory_read;
    logic                  memory_write;
    logic                  mux_ma;
    logic [DATA_WIDTH-1:0] imm;
    logic [FUNC_WIDTH-1:0] func;
  } ctl_t;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  ctl_t            ctl_q, ctl_d, dec;

  logic [FLAG_WIDTH-1:0] flag;
  logic [REG_WIDTH-1:0]  fld_ra, fld_rb;
  logic [FUNC_WIDTH-1:0] fld_fn;
  logic                  hazard, insn_ready, accept;

  assign flag   = bus_io.insn[INSN_WIDTH-1 -: FLAG_WIDTH];
  assign fld_ra = bus_io.insn[INSN_WIDTH-FLAG_WIDTH-1 -: REG_WIDTH];
  assign fld_rb = bus_io.insn[FUNC_WIDTH +: REG_WIDTH];
  assign fld_fn = bus_io.insn[FUNC_WIDTH-1:0];

  // Load-use: the word now on the outputs is a load whose destination is read by the offered op.
  assign hazard = (state_q == StRun) && bus_io.insn_valid && (flag == FlagOp) &&
                  ctl_q.valid && ctl_q.memory_read && ctl_q.reg_write &&
                  ((fld_ra == ctl_q.reg_a) || (fld_rb == ctl_q.reg_a));

  assign insn_ready = rst_n && !bus_io.stall && (state_q == StRun) && !hazard;
  assign accept     = bus_io.insn_valid && insn_ready;

  always_comb begin
    dec = '0;
    case (flag)
      FlagSet: begin
        dec.valid     = 1'b1;
        dec.reg_a     = fld_ra;
        dec.imm       = DATA_WIDTH'(bus_io.insn[ImmW-1:0]);
        dec.reg_write = 1'b1;
        dec.mux_ri    = 1'b1;
        dec.mux_ma    = 1'b1;
        dec.func      = FUNC_SET;
      end
      FlagBr: begin
        dec.valid    = 1'b1;
        dec.jump     = bus_io.insn[INSN_WIDTH-FLAG_WIDTH-1];
        dec.branch   = !bus_io.insn[INSN_WIDTH-FLAG_WIDTH-1];
        dec.relative = bus_io.insn[INSN_WIDTH-FLAG_WIDTH-2];
        dec.dest     = DATA_WIDTH'(bus_io.insn[TgtW-1:0]);
      end
      FlagOp: begin
        dec.valid = 1'b1;
        dec.reg_a = fld_ra;
        dec.reg_b = fld_rb;
        dec.func  = fld_fn;
        if (fld_fn == FUNC_LSS || fld_fn == FUNC_EQL || fld_fn == FUNC_GRT) begin
          dec.compare_write = 1'b1;
        end else if (fld_fn == FUNC_LD) begin
          dec.reg_write   = 1'b1;
          dec.memory_read = 1'b1;
        end else if (fld_fn == FUNC_SV) begin
          dec.memory_write = 1'b1;
        end else if (fld_fn == FUNC_ADD || fld_fn == FUNC_SUB) begin
          dec.reg_write      = 1'b1;
          dec.mux_ma         = 1'b1;
          dec.overflow_write = 1'b1;
        end else begin
          dec.reg_write = 1'b1;
          dec.mux_ma    = 1'b1;
        end
      end
      FlagSys: begin
        if (&bus_io.insn) dec.halt  = 1'b1;
        else              dec.valid = 1'b1;
      end
      default: dec = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      cnt_q   <= '0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctl_q   <= ctl_d;
    end
  end

  // Stall freezes state and counter outright.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!bus_io.stall) begin
      unique case (state_q)
        StRun: begin
          if (hazard) begin
            state_d = StStall;
          end else if (accept && dec.halt) begin
            state_d = StHalted;
          end else if (accept && (dec.branch || dec.jump)) begin
            state_d = StFlush;
            cnt_d   = CntW'(BRANCH_PENALTY - 1);
          end
        end
        StStall: state_d = StRun;
        StFlush: begin
          if (cnt_q == '0) state_d = StRun;
          else             cnt_d   = cnt_q - CntW'(1);
        end
        StHalted: state_d = StHalted;
        default:  state_d = StRun;
      endcase
    end
  end

  always_comb begin
    ctl_d = '0;
    if (bus_io.stall) begin
      ctl_d = ctl_q;
    end else if (state_q == StHalted) begin
      ctl_d.halt = 1'b1;
    end else if (accept) begin
      ctl_d = dec;
    end
  end

  assign bus_io.insn_ready       = insn_ready;
  assign bus_io.ctl_valid        = ctl_q.valid;
  assign bus_io.halt             = ctl_q.halt;
  assign bus_io.branch           = ctl_q.branch;
  assign bus_io.jump             = ctl_q.jump;
  assign bus_io.relative         = ctl_q.relative;
  assign bus_io.dest_branch_jump = ctl_q.dest;
  assign bus_io.reg_a            = ctl_q.reg_a;
  assign bus_io.reg_b            = ctl_q.reg_b;
  assign bus_io.reg_write        = ctl_q.reg_write;
  assign bus_io.mux_ri           = ctl_q.mux_ri;
  assign bus_io.overflow_write   = ctl_q.overflow_write;
  assign bus_io.compare_write    = ctl_q.compare_write;
  assign bus_io.memory_read      = ctl_q.memory_read;
  assign bus_io.memory_write     = ctl_q.memory_write;
  assign bus_io.mux_ma           = ctl_q.mux_ma;
  assign bus_io.immediate_value  = ctl_q.imm;
  assign bus_io.func_code        = ctl_q.func;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench for pipelined_control_unit: decode, load-use, flush, stall, halt.
module tb_pipelined_control_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  pipelined_control_unit_if bus ();

  pipelined_control_unit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus.stall = 1'b0;
    bus.insn_valid = 1'b0;
    bus.insn = '0;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.ctl_valid !== 1'b0) begin errors++;
      $display("FAIL reset_ctl_valid: got %b want 0", bus.ctl_valid); end
    checks++; if (bus.halt !== 1'b0) begin errors++;
      $display("FAIL reset_halt: got %b want 0", bus.halt); end
    checks++; if (bus.reg_write !== 1'b0) begin errors++;
      $display("FAIL reset_reg_write: got %b want 0", bus.reg_write); end
    checks++; if (bus.insn_ready !== 1'b0) begin errors++;
      $display("FAIL reset_ready: got %b want 0", bus.insn_ready); end
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_set();
    bus.insn_valid = 1'b1;
    bus.insn = 9'b00_10_00101;
    #1;
    checks++; if (bus.insn_ready !== 1'b1) begin errors++;
      $display("FAIL set_ready: got %b want 1", bus.insn_ready); end
    tick();
    bus.insn_valid = 1'b0;
    checks++; if (bus.ctl_valid !== 1'b1) begin errors++;
      $display("FAIL set_valid: got %b want 1", bus.ctl_valid); end
    checks++; if (bus.reg_a !== 2'd2) begin errors++;
      $display("FAIL set_reg_a: got %0d want 2", bus.reg_a); end
    checks++; if (bus.immediate_value !== 8'h05) begin errors++;
      $display("FAIL set_imm: got %h want 05", bus.immediate_value); end
    checks++; if ({bus.reg_write, bus.mux_ri, bus.mux_ma} !== 3'b111) begin errors++;
      $display("FAIL set_ctl: got %b want 111", {bus.reg_write, bus.mux_ri, bus.mux_ma}); end
    checks++; if (bus.func_code !== 3'd7) begin errors++;
      $display("FAIL set_func: got %0d want 7", bus.func_code); end
    tick();
    checks++; if ({bus.ctl_valid, bus.reg_write} !== 2'b00) begin errors++;
      $display("FAIL set_bubble: got %b want 00", {bus.ctl_valid, bus.reg_write}); end
  endtask

  task automatic test_load_use();
    bus.insn_valid = 1'b1;
    bus.insn = 9'b10_01_11_010;  // LD r1,[r3]
    tick();
    checks++; if ({bus.memory_read, bus.reg_write, bus.reg_a} !== 4'b11_01) begin errors++;
      $display("FAIL ld_word: got %b want 1101", {bus.memory_read, bus.reg_write, bus.reg_a}); end
    bus.insn = 9'b10_01_00_000;  // ADD r1,r0
    #1;
    checks++; if (bus.insn_ready !== 1'b0) begin errors++;
      $display("FAIL lu_hazard_ready: got %b want 0", bus.insn_ready); end
    tick();
    checks++; if ({bus.ctl_valid, bus.insn_ready} !== 2'b00) begin errors++;
      $display("FAIL lu_bubble: got %b want 00", {bus.ctl_valid, bus.insn_ready}); end
    tick();
    checks++; if (bus.insn_ready !== 1'b1) begin errors++;
      $display("FAIL lu_resume_ready: got %b want 1", bus.insn_ready); end
    tick();
    bus.insn_valid = 1'b0;
    checks++; if (bus.ctl_valid !== 1'b1) begin errors++;
      $display("FAIL add_valid: got %b want 1", bus.ctl_valid); end
    checks++; if ({bus.overflow_write, bus.reg_write, bus.mux_ma} !== 3'b111) begin errors++;
      $display("FAIL add_ctl: got %b want 111",
               {bus.overflow_write, bus.reg_write, bus.mux_ma}); end
    checks++; if ({bus.reg_a, bus.reg_b, bus.func_code} !== 7'b01_00_000) begin errors++;
      $display("FAIL add_fields: got %b want 0100000", {bus.reg_a, bus.reg_b, bus.func_code}); end
  endtask

  task automatic test_jump();
    bus.insn_valid = 1'b1;
    bus.insn = 9'b01_1_1_00011;
    tick();
    bus.insn = 9'b00_11_01010;
    checks++; if ({bus.jump, bus.relative, bus.branch} !== 3'b110) begin errors++;
      $display("FAIL jump_ctl: got %b want 110", {bus.jump, bus.relative, bus.branch}); end
    checks++; if (bus.dest_branch_jump !== 8'h03) begin errors++;
      $display("FAIL jump_dest: got %h want 03", bus.dest_branch_jump); end
    #1;
    checks++; if (bus.insn_ready !== 1'b0) begin errors++;
      $display("FAIL flush_ready0: got %b want 0", bus.insn_ready); end
    tick();
    checks++; if ({bus.ctl_valid, bus.insn_ready} !== 2'b00) begin errors++;
      $display("FAIL flush_ready1: got %b want 00", {bus.ctl_valid, bus.insn_ready}); end
    tick();
    checks++; if (bus.insn_ready !== 1'b1) begin errors++;
      $display("FAIL flush_end_ready: got %b want 1", bus.insn_ready); end
    bus.insn_valid = 1'b0;
  endtask

  task automatic test_stall();
    bus.insn_valid = 1'b1;
    bus.insn = 9'b10_10_11_101;  // EQL r2,r3
    tick();
    bus.stall = 1'b1;
    bus.insn = 9'b00_01_01001;   // SET r1,#9
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.insn_ready !== 1'b0) begin errors++;
        $display("FAIL stall_ready[%0d]: got %b want 0", i, bus.insn_ready); end
      tick();
      checks++; if ({bus.ctl_valid, bus.compare_write, bus.func_code} !== 5'b11_101) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got %b want 11101", i,
                 {bus.ctl_valid, bus.compare_write, bus.func_code}); end
    end
    bus.stall = 1'b0;
    #1;
    checks++; if (bus.insn_ready !== 1'b1) begin errors++;
      $display("FAIL unstall_ready: got %b want 1", bus.insn_ready); end
    tick();
    bus.insn_valid = 1'b0;
    checks++; if ({bus.ctl_valid, bus.reg_a, bus.immediate_value} !== 11'b1_01_00001001) begin
      errors++;
      $display("FAIL unstall_set: got %b want 10100001001",
               {bus.ctl_valid, bus.reg_a, bus.immediate_value}); end
  endtask

  task automatic test_nop();
    bus.insn_valid = 1'b1;
    bus.insn = 9'b11_0000000;
    tick();
    bus.insn_valid = 1'b0;
    checks++; if ({bus.ctl_valid, bus.halt} !== 2'b10) begin errors++;
      $display("FAIL nop_valid: got %b want 10", {bus.ctl_valid, bus.halt}); end
    checks++; if ({bus.reg_write, bus.mux_ma, bus.compare_write, bus.memory_write,
                   bus.func_code} !== 7'b0) begin errors++;
      $display("FAIL nop_ctl: got %b want 0", {bus.reg_write, bus.mux_ma, bus.compare_write,
               bus.memory_write, bus.func_code}); end
  endtask

  task automatic test_halt();
    bus.insn_valid = 1'b1;
    bus.insn = 9'h1FF;
    tick();
    checks++; if ({bus.halt, bus.ctl_valid} !== 2'b10) begin errors++;
      $display("FAIL halt_word: got %b want 10", {bus.halt, bus.ctl_valid}); end
    bus.insn = 9'b00_01_00001;
    for (int i = 0; i < 20; i++) begin
      #1;
      checks++; if (bus.insn_ready !== 1'b0) begin errors++;
        $display("FAIL halted_ready[%0d]: got %b want 0", i, bus.insn_ready); end
      tick();
      checks++; if ({bus.halt, bus.ctl_valid} !== 2'b10) begin errors++;
        $display("FAIL halted_hold[%0d]: got %b want 10", i, {bus.halt, bus.ctl_valid}); end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({bus.halt, bus.insn_ready, bus.ctl_valid} !== 3'b000) begin errors++;
      $display("FAIL halt_reset: got %b want 000", {bus.halt, bus.insn_ready, bus.ctl_valid}); end
    bus.insn_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_back_to_back();
    bus.insn_valid = 1'b1;
    bus.insn = 9'b10_00_01_011;  // SV r0,r1
    tick();
    checks++; if ({bus.memory_write, bus.reg_write, bus.ctl_valid} !== 3'b101) begin errors++;
      $display("FAIL sv_ctl: got %b want 101", {bus.memory_write, bus.reg_write, bus.ctl_valid}); end
    bus.insn = 9'b10_10_00_010;  // LD r2,[r0]
    tick();
    checks++; if ({bus.memory_read, bus.reg_a} !== 3'b1_10) begin errors++;
      $display("FAIL ld2_ctl: got %b want 110", {bus.memory_read, bus.reg_a}); end
    bus.insn = 9'b10_01_11_001;  // SUB r1,r3: no dependence on r2
    #1;
    checks++; if (bus.insn_ready !== 1'b1) begin errors++;
      $display("FAIL nohazard_ready: got %b want 1", bus.insn_ready); end
    tick();
    bus.insn_valid = 1'b0;
    checks++; if ({bus.func_code, bus.overflow_write, bus.memory_read} !== 5'b001_1_0) begin
      errors++;
      $display("FAIL sub_ctl: got %b want 00110",
               {bus.func_code, bus.overflow_write, bus.memory_read}); end
  endtask

  task automatic test_branch();
    bus.insn_valid = 1'b1;
    bus.insn = 9'b01_0_0_00111;
    #1;
    checks++; if (bus.insn_ready !== 1'b1) begin errors++;
      $display("FAIL br_ready: got %b want 1", bus.insn_ready); end
    tick();
    bus.insn_valid = 1'b0;
    checks++; if ({bus.ctl_valid, bus.branch, bus.jump, bus.relative} !== 4'b1100) begin
      errors++;
      $display("FAIL br_ctl: got %b want 1100",
               {bus.ctl_valid, bus.branch, bus.jump, bus.relative}); end
    checks++; if (bus.dest_branch_jump !== 8'h07) begin errors++;
      $display("FAIL br_dest: got %h want 07", bus.dest_branch_jump); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_set();
    test_load_use();
    test_jump();
    test_stall();
    test_nop();
    test_halt();
    test_back_to_back();
    test_branch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
Registered, parametrised successor to the combinational decoder; it sits between instruction fetch and the register file, ALU and data memory.
- Decodes one instruction per cycle into a registered control word.
- Uses a valid/ready handshake toward fetch and a stall input from downstream.
- Inserts a load-use bubble, flushes after branch/jump, and latches halt until reset.

Parameters:
FLAG_WIDTH, 2, opcode-class field width (insn MSBs)
REG_WIDTH, 2, register index width
FUNC_WIDTH, 3, ALU function code width
INSN_WIDTH, FLAG_WIDTH+2*REG_WIDTH+FUNC_WIDTH (9), instruction width
DATA_WIDTH, 8, width of immediate and destination outputs (zero-extended)
BRANCH_PENALTY, 2, cycles fetch is held off after issuing a branch/jump (>=1)
FUNC_ADD/SUB/LD/SV/LSS/EQL/GRT/SET, 0/1/2/3/4/5/6/7, function codes

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
insn_valid  in  1  fetch presents insn
insn  in  INSN_WIDTH  instruction
insn_ready  out  1  decoder accepts insn this cycle
stall  in  1  downstream hold; freezes control word
ctl_valid  out  1  control word below is a real instruction
halt, branch, jump, relative  out  1 each  fetch control
dest_branch_jump  out  DATA_WIDTH  branch/jump target
reg_a, reg_b  out  REG_WIDTH  register indices
reg_write, mux_ri, overflow_write, compare_write, memory_read, memory_write, mux_ma  out  1 each
immediate_value  out  DATA_WIDTH  immediate
func_code  out  FUNC_WIDTH  ALU function

Behaviour:
- Reset (async, rst_n=0): every output is 0, state=RUN, penalty counter=0. insn_ready=0 while in reset.
- Instruction layout (MSB first):
  - flag: 00 SET, 01 BR/JMP, 10 OP, 11 SYS.
  - SET: reg_a field, immediate in the remaining low bits.
  - BR/JMP: bit[INSN_WIDTH-3] 0=branch/1=jump, next bit relative, remaining low bits target.
  - OP: reg_a, reg_b, func.
  - SYS: all-ones = HALT; any other SYS value = NOP (ctl_valid=1, all controls 0).
- Decode rules:
  - SET: reg_write, mux_ri, mux_ma=1; func_code=FUNC_SET.
  - BR/JMP: branch or jump, relative, dest_branch_jump driven from the instruction.
  - OP with LSS/EQL/GRT: compare_write=1.
  - OP with LD: reg_write, memory_read=1.
  - OP with SV: memory_write=1.
  - OP with ADD/SUB: reg_write, mux_ma, overflow_write=1.
  - OP with other func: reg_write, mux_ma=1.
  - OP always drives reg_a, reg_b and func_code.
- Latency: accepted insn (insn_valid & insn_ready at edge) appears on the outputs on the next edge (1 cycle).
- Handshake: the control word holds while stall=1. insn_ready=0 if stall=1 or state is STALL, FLUSH or HALTED. If no insn is accepted, the next word is a bubble (ctl_valid=0, all controls 0).
- States:
  - RUN: normal decode.
  - STALL (load-use): entered when the current word is LD with reg_write and the offered OP insn has reg_a or reg_b equal to that LD's reg_a. The insn is not accepted, a bubble is emitted, and state returns to RUN after exactly 1 cycle. SET never triggers STALL.
  - FLUSH: entered on the edge a branch/jump is issued. The counter loads BRANCH_PENALTY-1 and insn_ready=0 until it expires, then RUN. A branch issued while stall=1 enters FLUSH only once stall falls.
  - HALTED: entered when HALT is issued. halt output stays 1 and ctl_valid stays 0 afterwards. insn_ready=0. Exit only via reset.
- Simultaneous events: stall has priority over all transitions (state and counter frozen). Reset mid-FLUSH/STALL returns to RUN with cleared outputs.

Test Plan:
- Reset then offer SET r2,#5 (insn 9'b00_10_00101) -> next cycle ctl_valid=1, reg_a=2, immediate_value=8'h05, reg_write=mux_ri=mux_ma=1, func_code=7.
- OP LD r1,[r3] then OP ADD r1,r0 back-to-back -> one bubble cycle (ctl_valid=0, insn_ready=0), then ADD with overflow_write=1, reg_write=1.
- Jump relative 9'b01_1_1_00011 -> jump=1, relative=1, dest=8'h03; insn_ready=0 for the next BRANCH_PENALTY=2 cycles, then 1.
- Hold stall=1 for 3 cycles with an EQL word issued -> outputs frozen (compare_write=1), insn_ready=0; release -> next insn accepted.
- Offer 9'h1FF -> halt=1 next cycle, remains 1 and insn_ready=0 for 20 cycles; pull rst_n low mid-cycle -> halt=0 immediately.
- Offer SYS 9'b11_0000000 -> ctl_valid=1, all controls 0, no halt.
